udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Round-robin arbiter and packet framer sharing the single UDP transmit path (header + 8-bit payload stream into the UDP stack) between `N_SRC` byte-stream requesters. Each requester declares a payload length and destination port, and the arbiter grants one requester at a time. For the granted requester it issues one UDP header with the computed `udp_length`, then forwards exactly the declared number of payload bytes with a generated `tlast`. It sits between application byte producers and the UDP stack's `udp_in`/payload input, replacing fixed always-valid header driving.

## Interface
- `N_SRC`, 4: number of requesters (2..8).
- `SRC_IP`, 192.168.1.128: 32-bit `udp_ip_source_ip`.
- `DST_IP`, 192.168.1.127: 32-bit `udp_ip_dest_ip`.
- `SRC_PORT`, 3000: `udp_source_port`.
- `IP_TTL`, 64: `udp_ip_ttl`.
- `TIMEOUT_CYCLES`, 1024: stall limit; used only with `UDP_TX_ARB_TIMEOUT_EN`.

Ports:
- `udp_sys_clk`  in  1  single clock; all logic on rising edge.
- `system_reset_n`  in  1  asynchronous assert, active-low reset.
- `src_req`  in  N_SRC  per-source request, level; held until grant.
- `src_len`  in  16*N_SRC  payload byte count, sampled at grant.
- `src_dest_port`  in  16*N_SRC  destination port, sampled at grant.
- `src_grant`  out  N_SRC  one-hot grant; held from grant until the packet completes.
- `src_tdata`  in  8*N_SRC  payload bytes.
- `src_tvalid` / `src_tlast`  in  N_SRC  payload valid / source end marker.
- `src_tready`  out  N_SRC  payload ready; only the granted bit can be 1.
- `udp_hdr_valid`  out  1 / `udp_hdr_ready`  in  1  header handshake.
- `udp_length`, `udp_dest_port`  out  16 each  header fields.
- `udp_source_port`, `udp_ip_source_ip`, `udp_ip_ttl`  out  16/32/8  constants from parameters.
- `udp_ip_dest_ip`  out  32  constant from `DST_IP`.
- `udp_ip_dscp`, `udp_ip_ecn`, `udp_checksum`  out  6/2/16  always 0.
- `m_tdata`  out  8 / `m_tvalid`, `m_tlast`, `m_tuser`  out  1 / `m_tready`  in  1  payload to the UDP stack; `m_tkeep`=1, `m_tid`=`m_tdest`=0.
- `len_error`  out  1  one-cycle pulse when source framing mismatches the declared length.
- `timeout`  out  1  one-cycle pulse on watchdog abort.
- `pkt_count`  out  16  completed packets, wraps at 65535→0.

## Operation
- States:
  - **IDLE**: if any `src_req`, grant the first requesting index at or after `rr_ptr` (wrapping); latch the effective length and port; go to **HDR**.
  - **HDR**: `udp_hdr_valid`=1, fields stable; on `udp_hdr_ready`, go to **PAYLOAD** with `cnt`=0.
  - **PAYLOAD**: pass the granted source through; `m_tlast` = (`cnt` == len−1); each `m_tvalid && m_tready` increments `cnt`.
  - **PAD**: drive `m_tdata`=0, `m_tvalid`=1, `src_tready`=0 until `cnt` reaches len; `m_tuser`=1 on the final beat.
  - **DRAIN**: `src_tready`=1, `m_tvalid`=0; discard source bytes through the source's `src_tlast` beat, then go to IDLE.
- Effective length: `src_len`==0 is treated as 1; `src_len`>65527 is clamped to 65527. `udp_length` = effective length + 8.
- Short source (`src_tlast` accepted with `cnt` < len−1): pulse `len_error`, go to PAD.
- Long source (final output beat accepted while the source `tlast` is 0): pulse `len_error`, go to DRAIN.
- Packet complete, either on the final output beat when the source `tlast` agrees, or on the PAD final beat:
  - `pkt_count` increments;
  - `rr_ptr` = granted index + 1, mod `N_SRC`;
  - `src_grant` clears;
  - return to IDLE.
- A request deasserted after grant has no effect; the packet completes.

## Timing
- Reset (asynchronous, `system_reset_n`=0): state IDLE, `src_grant`=0, `udp_hdr_valid`=0, `m_tvalid`=0, `m_tlast`=0, `m_tuser`=0, `src_tready`=0, `len_error`=0, `timeout`=0, `pkt_count`=0, `rr_ptr`=0, `cnt`=0, `udp_length`=0, `udp_dest_port`=0. Reset mid-packet drops the packet silently.
- `src_req` sampled at edge T → `src_grant` and `udp_hdr_valid` high from T+1.
- Payload path is combinational (zero latency): `m_tdata`/`m_tvalid` follow the source, and `src_tready` = `m_tready`, in PAYLOAD only.
- Minimum gap: one IDLE cycle between packets, so a back-to-back single-byte packet takes at least 3 cycles.
- `udp_hdr_valid` never drops before `udp_hdr_ready`; header fields are constant while valid.

## Configuration
- `UDP_TX_ARB_TIMEOUT_EN` defined: a stall counter runs in PAYLOAD and is cleared by any accepted beat.
  - When it reaches `TIMEOUT_CYCLES` with the source `tvalid` low, pulse `timeout` and go to PAD.
  - The abandoned source bytes are never drained.
- Not defined: no counter; PAYLOAD waits indefinitely; `timeout` is tied to 0.

## Test plan
- Src1 requests len=4, port 5000, and sends 4 bytes with `tlast` on the 4th → header `udp_length`=12, `udp_dest_port`=5000; `m_tlast` on the 4th byte; `pkt_count`=1.
- All 4 sources request continuously, each with len=2 → grant order 0,1,2,3,0; no overlapping grants.
- Source declares len=5 but asserts `tlast` after 3 bytes → `len_error` pulse; 2 zero bytes padded; `m_tuser`=1 on the 5th beat.
- Source declares len=2 but sends 4 bytes → 2 bytes forwarded with `m_tlast` on the 2nd; `len_error` pulse; bytes 3–4 drained; next grant follows.
- `src_len`=0 → `udp_length`=9 with one byte forwarded. `src_len`=65535 → `udp_length`=65535. `m_tready` held low 10 cycles mid-packet → no byte lost or duplicated.
- Macro defined, `TIMEOUT_CYCLES`=16, source stalls after 1 of 3 bytes → `timeout` pulse 16 cycles after the last accepted beat; 2 pad bytes sent; `m_tuser`=1.

Source files
------------

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: UDP header fields plus the 8-bit payload stream
// between the transmit arbiter (master) and the UDP stack (slave).
interface udp_tx_arbiter_if;
  logic        udp_hdr_valid;
  logic        udp_hdr_ready;
  logic [15:0] udp_length;
  logic [15:0] udp_dest_port;
  logic [15:0] udp_source_port;
  logic [31:0] udp_ip_source_ip;
  logic [31:0] udp_ip_dest_ip;
  logic [7:0]  udp_ip_ttl;
  logic [5:0]  udp_ip_dscp;
  logic [1:0]  udp_ip_ecn;
  logic [15:0] udp_checksum;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tkeep;
  logic [7:0]  m_tid;
  logic [7:0]  m_tdest;

  modport master (
    output udp_hdr_valid, udp_length, udp_dest_port, udp_source_port,
           udp_ip_source_ip, udp_ip_dest_ip, udp_ip_ttl, udp_ip_dscp,
           udp_ip_ecn, udp_checksum,
           m_tdata, m_tvalid, m_tlast, m_tuser, m_tkeep, m_tid, m_tdest,
    input  udp_hdr_ready, m_tready
  );

  modport slave (
    input  udp_hdr_valid, udp_length, udp_dest_port, udp_source_port,
           udp_ip_source_ip, udp_ip_dest_ip, udp_ip_ttl, udp_ip_dscp,
           udp_ip_ecn, udp_checksum,
           m_tdata, m_tvalid, m_tlast, m_tuser, m_tkeep, m_tid, m_tdest,
    output udp_hdr_ready, m_tready
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin arbiter and packet framer for the UDP transmit
// path. Grants one byte-stream source at a time, emits one header with the
// computed udp_length, then forwards exactly the declared payload length,
// padding short sources and draining long ones.
// Optional macro UDP_TX_ARB_TIMEOUT_EN: payload stall watchdog that aborts
// into zero padding after TIMEOUT_CYCLES idle cycles.
module udp_tx_arbiter #(
  parameter int          N_SRC          = 4,
  parameter logic [31:0] SRC_IP         = 32'hC0A8_0180,
  parameter logic [31:0] DST_IP         = 32'hC0A8_017F,
  parameter logic [15:0] SRC_PORT       = 16'd3000,
  parameter logic [7:0]  IP_TTL         = 8'd64,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  udp_sys_clk,
  input  logic                  system_reset_n,
  input  logic [N_SRC-1:0]      src_req,
  input  logic [16*N_SRC-1:0]   src_len,
  input  logic [16*N_SRC-1:0]   src_dest_port,
  output logic [N_SRC-1:0]      src_grant,
  input  logic [8*N_SRC-1:0]    src_tdata,
  input  logic [N_SRC-1:0]      src_tvalid,
  input  logic [N_SRC-1:0]      src_tlast,
  output logic [N_SRC-1:0]      src_tready,
  udp_tx_arbiter_if.master      udp,
  output logic                  len_error,
  output logic                  timeout,
  output logic [15:0]           pkt_count
);
  localparam int          IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [15:0] MAX_LEN = 16'd65527;

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_PAD, ST_DRAIN} state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  gnt_idx_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [15:0]       len_r;
  logic [15:0]       cnt_r;
  logic              hdr_valid_r;
  logic [15:0]       udp_length_r;
  logic [15:0]       udp_dest_port_r;

  int                cand_s;
  logic              pick_vld_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [15:0]       pick_len_s;
  logic [15:0]       pick_port_s;
  logic [7:0]        sel_tdata_s;
  logic              sel_tvalid_s;
  logic              sel_tlast_s;
  logic              last_beat_s;
  logic              beat_s;
  logic [IDX_W-1:0]  next_ptr_s;

  // Zero-length requests still carry one byte; oversize ones are clamped so
  // that udp_length (payload + 8) fits in 16 bits.
  function automatic logic [15:0] eff_len(input logic [15:0] raw);
    if (raw == 16'd0) begin
      eff_len = 16'd1;
    end else if (raw > MAX_LEN) begin
      eff_len = MAX_LEN;
    end else begin
      eff_len = raw;
    end
  endfunction

  assign udp.udp_hdr_valid    = hdr_valid_r;
  assign udp.udp_length       = udp_length_r;
  assign udp.udp_dest_port    = udp_dest_port_r;
  assign udp.udp_source_port  = SRC_PORT;
  assign udp.udp_ip_source_ip = SRC_IP;
  assign udp.udp_ip_dest_ip   = DST_IP;
  assign udp.udp_ip_ttl       = IP_TTL;
  assign udp.udp_ip_dscp      = 6'd0;
  assign udp.udp_ip_ecn       = 2'd0;
  assign udp.udp_checksum     = 16'd0;
  assign udp.m_tkeep          = 1'b1;
  assign udp.m_tid            = 8'd0;
  assign udp.m_tdest          = 8'd0;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    cand_s      = 0;
    pick_vld_s  = 1'b0;
    pick_idx_s  = '0;
    pick_len_s  = 16'd1;
    pick_port_s = 16'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cand_s = int'(rr_ptr_r) + i;
      if (cand_s >= N_SRC) begin
        cand_s = cand_s - N_SRC;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_vld_s && src_req[cand_s]) begin
        pick_vld_s  = 1'b1;
        pick_idx_s  = IDX_W'(cand_s);
        pick_len_s  = eff_len(src_len[16*cand_s +: 16]);
        pick_port_s = src_dest_port[16*cand_s +: 16];
      end else begin
        pick_vld_s  = pick_vld_s;
      end
    end
  end

  // Granted-source view and beat bookkeeping shared by FSM and output mux.
  always_comb begin
    sel_tdata_s  = src_tdata[8*int'(gnt_idx_r) +: 8];
    sel_tvalid_s = src_tvalid[gnt_idx_r];
    sel_tlast_s  = src_tlast[gnt_idx_r];
    last_beat_s  = (cnt_r == (len_r - 16'd1));
    beat_s       = sel_tvalid_s & udp.m_tready;
    if (gnt_idx_r == IDX_W'(N_SRC - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_r + IDX_W'(1);
    end
  end

  // Zero-latency payload path: pass-through in PAYLOAD, zeros in PAD,
  // sink-only in DRAIN, quiet elsewhere.
  always_comb begin
    udp.m_tdata  = 8'd0;
    udp.m_tvalid = 1'b0;
    udp.m_tlast  = 1'b0;
    udp.m_tuser  = 1'b0;
    src_tready   = '0;
    case (state_r)
      ST_PAYLOAD: begin
        udp.m_tdata           = sel_tdata_s;
        udp.m_tvalid          = sel_tvalid_s;
        udp.m_tlast           = last_beat_s;
        src_tready[gnt_idx_r] = udp.m_tready;
      end
      ST_PAD: begin
        udp.m_tvalid = 1'b1;
        udp.m_tlast  = last_beat_s;
        udp.m_tuser  = last_beat_s;
      end
      ST_DRAIN: begin
        src_tready[gnt_idx_r] = 1'b1;
      end
      default: begin
        udp.m_tvalid = 1'b0;
      end
    endcase
  end

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] STALL_LIM = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] stall_r;
  logic        timeout_r;
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  // Arbitration / framing FSM with registered grant, header and status.
  always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_r         <= ST_IDLE;
      gnt_idx_r       <= '0;
      rr_ptr_r        <= '0;
      len_r           <= 16'd1;
      cnt_r           <= 16'd0;
      hdr_valid_r     <= 1'b0;
      udp_length_r    <= 16'd0;
      udp_dest_port_r <= 16'd0;
      src_grant       <= '0;
      len_error       <= 1'b0;
      pkt_count       <= 16'd0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      stall_r         <= 32'd0;
      timeout_r       <= 1'b0;
`endif
    end else begin
      len_error <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pick_vld_s) begin
            gnt_idx_r       <= pick_idx_s;
            src_grant       <= {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx_s;
            len_r           <= pick_len_s;
            udp_length_r    <= pick_len_s + 16'd8;
            udp_dest_port_r <= pick_port_s;
            hdr_valid_r     <= 1'b1;
            state_r         <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (udp.udp_hdr_ready) begin
            hdr_valid_r <= 1'b0;
            cnt_r       <= 16'd0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
            stall_r     <= 32'd0;
`endif
            state_r     <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (beat_s) begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
            stall_r <= 32'd0;
`endif
            if (last_beat_s) begin
              if (sel_tlast_s) begin
                pkt_count <= pkt_count + 16'd1;
                rr_ptr_r  <= next_ptr_s;
                src_grant <= '0;
                state_r   <= ST_IDLE;
              end else begin
                // Source has more bytes than declared: discard the rest.
                len_error <= 1'b1;
                state_r   <= ST_DRAIN;
              end
            end else if (sel_tlast_s) begin
              // Source ended early: fill the declared length with zeros.
              len_error <= 1'b1;
              cnt_r     <= cnt_r + 16'd1;
              state_r   <= ST_PAD;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end else begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
            if (!sel_tvalid_s && (stall_r >= STALL_LIM)) begin
              timeout_r <= 1'b1;
              stall_r   <= 32'd0;
              state_r   <= ST_PAD;
            end else if (stall_r < STALL_LIM) begin
              stall_r <= stall_r + 32'd1;
            end else begin
              stall_r <= stall_r;
            end
`endif
          end
        end
        ST_PAD: begin
          if (udp.m_tready) begin
            if (last_beat_s) begin
              pkt_count <= pkt_count + 16'd1;
              rr_ptr_r  <= next_ptr_s;
              src_grant <= '0;
              state_r   <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (sel_tvalid_s && sel_tlast_s) begin
            rr_ptr_r  <= next_ptr_s;
            src_grant <= '0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed scenarios for the UDP transmit arbiter.
module tb_udp_tx_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_req;
  logic [16*N-1:0] src_len;
  logic [16*N-1:0] src_dest_port;
  logic [N-1:0]    src_grant;
  logic [8*N-1:0]  src_tdata;
  logic [N-1:0]    src_tvalid;
  logic [N-1:0]    src_tlast;
  logic [N-1:0]    src_tready;
  logic            len_error;
  logic            timeout;
  logic [15:0]     pkt_count;

  int checks = 0;
  int errors = 0;

  udp_tx_arbiter_if u_if();

  udp_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYCLES(16)) dut (
    .udp_sys_clk    (clk),
    .system_reset_n (rst_n),
    .src_req        (src_req),
    .src_len        (src_len),
    .src_dest_port  (src_dest_port),
    .src_grant      (src_grant),
    .src_tdata      (src_tdata),
    .src_tvalid     (src_tvalid),
    .src_tlast      (src_tlast),
    .src_tready     (src_tready),
    .udp            (u_if),
    .len_error      (len_error),
    .timeout        (timeout),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  // Monitor: records accepted output beats {tuser,tlast,data} and pulses.
  logic [9:0] mon_q[$];
  int         beat_cyc_q[$];
  int         cyc = 0;
  int         lerr_cnt = 0;
  int         to_cnt = 0;
  int         to_cyc = 0;
  int         overlap_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.m_tvalid && u_if.m_tready) begin
      mon_q.push_back({u_if.m_tuser, u_if.m_tlast, u_if.m_tdata});
      beat_cyc_q.push_back(cyc);
    end
    if (len_error) lerr_cnt <= lerr_cnt + 1;
    if (timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if ($countones(src_grant) > 1) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (src_grant != '0) break;
    end
    for (int i = 0; i < N; i++) if (src_grant[i]) idx = i;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (src_grant == '0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Drive n bytes base, base+1, ... on source idx; tlast on the last if asked.
  task automatic feed(input int idx, input int n, input logic [7:0] base,
                      input bit last_flag, output bit ok);
    bit acc;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      src_tvalid[idx]        = 1'b1;
      src_tdata[idx*8 +: 8]  = base + 8'(k);
      src_tlast[idx]         = last_flag && (k == n - 1);
      acc = 1'b0;
      for (int w = 0; w < 100 && !acc; w++) begin
        @(negedge clk);
        acc = src_tready[idx];
        @(posedge clk); #1;
      end
      if (!acc) ok = 1'b0;
    end
    src_tvalid[idx] = 1'b0;
    src_tlast[idx]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_req = '0; src_len = '0; src_dest_port = '0;
    src_tdata = '0; src_tvalid = '0; src_tlast = '0;
    u_if.udp_hdr_ready = 1'b1;
    u_if.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({src_grant, src_tready, u_if.udp_hdr_valid, u_if.m_tvalid, u_if.m_tlast,
         u_if.m_tuser, len_error, timeout} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b tready=%b hv=%b tv=%b tl=%b tu=%b le=%b to=%b, required all 0",
               src_grant, src_tready, u_if.udp_hdr_valid, u_if.m_tvalid, u_if.m_tlast,
               u_if.m_tuser, len_error, timeout);
    end
    checks++;
    if ({pkt_count, u_if.udp_length, u_if.udp_dest_port} !== 48'd0) begin
      errors++;
      $display("FAIL reset_regs: pkt=%0d len=%0d port=%0d, required 0 0 0",
               pkt_count, u_if.udp_length, u_if.udp_dest_port);
    end
    checks++;
    if (u_if.udp_source_port !== 16'd3000 || u_if.udp_ip_source_ip !== 32'hC0A80180 ||
        u_if.udp_ip_dest_ip !== 32'hC0A8017F || u_if.udp_ip_ttl !== 8'd64) begin
      errors++;
      $display("FAIL hdr_const: sport=%0d sip=%h dip=%h ttl=%0d, required 3000 c0a80180 c0a8017f 64",
               u_if.udp_source_port, u_if.udp_ip_source_ip, u_if.udp_ip_dest_ip, u_if.udp_ip_ttl);
    end
    checks++;
    if (u_if.udp_checksum !== 16'd0 || u_if.udp_ip_dscp !== 6'd0 || u_if.udp_ip_ecn !== 2'd0 ||
        u_if.m_tkeep !== 1'b1 || u_if.m_tid !== 8'd0 || u_if.m_tdest !== 8'd0) begin
      errors++;
      $display("FAIL hdr_zero: csum=%h dscp=%h ecn=%h keep=%b id=%h dest=%h, required 0 0 0 1 0 0",
               u_if.udp_checksum, u_if.udp_ip_dscp, u_if.udp_ip_ecn, u_if.m_tkeep, u_if.m_tid, u_if.m_tdest);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int base;
    int idx;
    bit ok;
    logic [15:0] pc0;
    base = mon_q.size();
    pc0  = pkt_count;
    for (int i = 0; i < N; i++) begin
      src_len[16*i +: 16]       = 16'd2;
      src_dest_port[16*i +: 16] = 16'd100 + 16'(i);
    end
    src_req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_grant(idx);
      checks++;
      if (idx !== exp_order[p]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", p, idx, exp_order[p]);
      end
      if (p == 4) src_req = '0;
      ok = 1'b0;
      if (idx >= 0) feed(idx, 2, 8'h20 + 8'(2*p), 1'b1, ok);
      wait_idle(ok);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL rr_overlap: %0d cycles with several grants, required 0", overlap_cnt);
    end
    checks++;
    if (16'(pkt_count - pc0) !== 16'd5) begin
      errors++;
      $display("FAIL rr_pkts: got %0d packets, required 5", 16'(pkt_count - pc0));
    end
    checks++;
    if (mon_q.size() - base !== 10) begin
      errors++;
      $display("FAIL rr_beats: got %0d beats, required 10", mon_q.size() - base);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (mon_q[base+k] !== {1'b0, (k % 2 == 1), 8'h20 + 8'(k)}) begin
          errors++;
          $display("FAIL rr_beat[%0d]: got %h, required %h", k, mon_q[base+k],
                   {1'b0, (k % 2 == 1), 8'h20 + 8'(k)});
        end
      end
    end
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    logic [15:0] pc0;
    base = mon_q.size();
    pc0  = pkt_count;
    src_len[16 +: 16]       = 16'd4;
    src_dest_port[16 +: 16] = 16'd5000;
    src_req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (src_grant !== 4'b0000) begin
      errors++;
      $display("FAIL basic_pre_grant: got %b, required 0000", src_grant);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (src_grant !== 4'b0010 || u_if.udp_hdr_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant: grant=%b hdr_valid=%b, required 0010 1", src_grant, u_if.udp_hdr_valid);
    end
    checks++;
    if (u_if.udp_length !== 16'd12 || u_if.udp_dest_port !== 16'd5000) begin
      errors++;
      $display("FAIL basic_hdr: len=%0d port=%0d, required 12 5000", u_if.udp_length, u_if.udp_dest_port);
    end
    src_req[1] = 1'b0;
    feed(1, 4, 8'h10, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_feed: source stalled, required 4 accepted bytes");
    end
    wait_idle(ok);
    checks++;
    if (mon_q.size() - base !== 4) begin
      errors++;
      $display("FAIL basic_beats: got %0d, required 4", mon_q.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (mon_q[base+k] !== {1'b0, (k == 3), 8'h10 + 8'(k)}) begin
          errors++;
          $display("FAIL basic_beat[%0d]: got %h, required %h", k, mon_q[base+k], {1'b0, (k == 3), 8'h10 + 8'(k)});
        end
      end
    end
    checks++;
    if (16'(pkt_count - pc0) !== 16'd1 || src_grant !== 4'b0000) begin
      errors++;
      $display("FAIL basic_done: pkts=%0d grant=%b, required 1 0000", 16'(pkt_count - pc0), src_grant);
    end
  endtask

  task automatic test_short_source();
    logic [9:0] exp_b[5] = '{10'h030, 10'h031, 10'h032, 10'h000, 10'h300};
    int base, le0, idx;
    bit ok;
    logic [15:0] pc0;
    base = mon_q.size(); le0 = lerr_cnt; pc0 = pkt_count;
    src_len[32 +: 16] = 16'd5;
    src_req[2] = 1'b1;
    wait_grant(idx);
    src_req[2] = 1'b0;
    checks++;
    if (idx !== 2) begin
      errors++;
      $display("FAIL short_grant: got %0d, required 2", idx);
    end
    feed(2, 3, 8'h30, 1'b1, ok);
    wait_idle(ok);
    checks++;
    if (!ok || lerr_cnt - le0 !== 1) begin
      errors++;
      $display("FAIL short_lenerr: idle=%b pulses=%0d, required 1 1", ok, lerr_cnt - le0);
    end
    checks++;
    if (mon_q.size() - base !== 5) begin
      errors++;
      $display("FAIL short_beats: got %0d, required 5", mon_q.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (mon_q[base+k] !== exp_b[k]) begin
          errors++;
          $display("FAIL short_beat[%0d]: got %h, required %h", k, mon_q[base+k], exp_b[k]);
        end
      end
    end
    checks++;
    if (16'(pkt_count - pc0) !== 16'd1) begin
      errors++;
      $display("FAIL short_pkts: got %0d, required 1", 16'(pkt_count - pc0));
    end
  endtask

  task automatic test_long_source();
    int base, le0, idx;
    bit ok;
    base = mon_q.size(); le0 = lerr_cnt;
    src_len[48 +: 16] = 16'd2;
    src_req[3] = 1'b1;
    wait_grant(idx);
    src_req[3] = 1'b0;
    feed(3, 4, 8'h40, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL long_drain_feed: extra bytes not accepted, required drained");
    end
    wait_idle(ok);
    checks++;
    if (!ok || lerr_cnt - le0 !== 1) begin
      errors++;
      $display("FAIL long_lenerr: idle=%b pulses=%0d, required 1 1", ok, lerr_cnt - le0);
    end
    checks++;
    if (mon_q.size() - base !== 2) begin
      errors++;
      $display("FAIL long_beats: got %0d, required 2", mon_q.size() - base);
    end else begin
      checks++;
      if (mon_q[base] !== 10'h040 || mon_q[base+1] !== 10'h141) begin
        errors++;
        $display("FAIL long_data: got %h %h, required 040 141", mon_q[base], mon_q[base+1]);
      end
    end
    base = mon_q.size();
    src_len[0 +: 16] = 16'd1;
    src_req[0] = 1'b1;
    wait_grant(idx);
    src_req[0] = 1'b0;
    checks++;
    if (idx !== 0) begin
      errors++;
      $display("FAIL long_next_grant: got %0d, required 0", idx);
    end
    feed(0, 1, 8'h50, 1'b1, ok);
    wait_idle(ok);
    checks++;
    if (mon_q.size() - base !== 1 || mon_q[base] !== 10'h150) begin
      errors++;
      $display("FAIL long_next_pkt: beats=%0d first=%h, required 1 150", mon_q.size() - base, mon_q[base]);
    end
  endtask

  task automatic test_backpressure();
    int base, idx;
    bit ok;
    base = mon_q.size();
    src_len[16 +: 16] = 16'd6;
    src_req[1] = 1'b1;
    wait_grant(idx);
    src_req[1] = 1'b0;
    fork
      feed(1, 6, 8'h70, 1'b1, ok);
      begin
        repeat (4) @(posedge clk);
        #1 u_if.m_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1 u_if.m_tready = 1'b1;
      end
    join
    wait_idle(ok);
    checks++;
    if (mon_q.size() - base !== 6) begin
      errors++;
      $display("FAIL bp_beats: got %0d, required 6", mon_q.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (mon_q[base+k] !== {1'b0, (k == 5), 8'h70 + 8'(k)}) begin
          errors++;
          $display("FAIL bp_beat[%0d]: got %h, required %h", k, mon_q[base+k], {1'b0, (k == 5), 8'h70 + 8'(k)});
        end
      end
    end
  endtask

  task automatic test_timeout();
`ifdef UDP_TX_ARB_TIMEOUT_EN
    logic [9:0] exp_b[3] = '{10'h080, 10'h000, 10'h300};
    int base, to0, le0, idx;
    bit ok;
    base = mon_q.size(); to0 = to_cnt; le0 = lerr_cnt;
    src_len[32 +: 16] = 16'd3;
    src_req[2] = 1'b1;
    wait_grant(idx);
    src_req[2] = 1'b0;
    feed(2, 1, 8'h80, 1'b0, ok);
    wait_idle(ok);
    checks++;
    if (!ok || to_cnt - to0 !== 1 || lerr_cnt - le0 !== 0) begin
      errors++;
      $display("FAIL to_pulse: idle=%b timeouts=%0d lenerr=%0d, required 1 1 0", ok, to_cnt - to0, lerr_cnt - le0);
    end
    checks++;
    if (mon_q.size() - base !== 3) begin
      errors++;
      $display("FAIL to_beats: got %0d, required 3", mon_q.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (mon_q[base+k] !== exp_b[k]) begin
          errors++;
          $display("FAIL to_beat[%0d]: got %h, required %h", k, mon_q[base+k], exp_b[k]);
        end
      end
      checks++;
      if (to_cyc - beat_cyc_q[base] !== 17) begin
        errors++;
        $display("FAIL to_delay: got %0d, required 17", to_cyc - beat_cyc_q[base]);
      end
    end
`else
    checks++;
    if (to_cnt !== 0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_disabled: pulses=%0d timeout=%b, required 0 0", to_cnt, timeout);
    end
`endif
  endtask

  task automatic test_len_edges();
    int base, le0, idx;
    bit ok;
    base = mon_q.size(); le0 = lerr_cnt;
    src_len[0 +: 16]       = 16'd0;
    src_dest_port[0 +: 16] = 16'd7;
    src_req[0] = 1'b1;
    wait_grant(idx);
    src_req[0] = 1'b0;
    checks++;
    if (u_if.udp_length !== 16'd9 || u_if.udp_dest_port !== 16'd7) begin
      errors++;
      $display("FAIL len0_hdr: len=%0d port=%0d, required 9 7", u_if.udp_length, u_if.udp_dest_port);
    end
    feed(0, 1, 8'h60, 1'b1, ok);
    wait_idle(ok);
    checks++;
    if (mon_q.size() - base !== 1 || mon_q[base] !== 10'h160 || lerr_cnt !== le0) begin
      errors++;
      $display("FAIL len0_pkt: beats=%0d first=%h lenerr=%0d, required 1 160 0",
               mon_q.size() - base, mon_q[base], lerr_cnt - le0);
    end
    u_if.udp_hdr_ready = 1'b0;
    src_len[32 +: 16] = 16'hFFFF;
    src_req[2] = 1'b1;
    wait_grant(idx);
    src_req[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (u_if.udp_hdr_valid !== 1'b1 || u_if.udp_length !== 16'd65535) begin
        errors++;
        $display("FAIL lenmax_hdr[%0d]: valid=%b len=%0d, required 1 65535", k, u_if.udp_hdr_valid, u_if.udp_length);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (src_grant !== 4'b0000 || u_if.udp_hdr_valid !== 1'b0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b hv=%b pkt=%0d, required 0000 0 0", src_grant, u_if.udp_hdr_valid, pkt_count);
    end
    @(posedge clk); #1;
    u_if.udp_hdr_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_basic();
    test_short_source();
    test_long_source();
    test_backpressure();
    test_timeout();
    test_len_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
